// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle CPU control unit: Moore FSM sequencing IF/ID/EX/MEM/WB.
// Drives datapath enables, one-hot B/~B operand strobes and a retire counter.
module mc_ctrl_fsm #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             ir_we,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             mem_iord,
    output logic             reg_we,
    output logic             reg_dst,
    output logic             mem2reg,
    output logic             b_sel,
    output logic             bn_sel,
    output logic [2:0]       alu_op,
    output logic             trap,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [3:0] S_RST    = 4'd0;
    localparam logic [3:0] S_IF     = 4'd1;
    localparam logic [3:0] S_ID     = 4'd2;
    localparam logic [3:0] S_EX_R   = 4'd3;
    localparam logic [3:0] S_EX_AD  = 4'd4;
    localparam logic [3:0] S_MEM_RD = 4'd5;
    localparam logic [3:0] S_MEM_WR = 4'd6;
    localparam logic [3:0] S_WB_R   = 4'd7;
    localparam logic [3:0] S_WB_MEM = 4'd8;
    localparam logic [3:0] S_EX_BR  = 4'd9;
    localparam logic [3:0] S_EX_J   = 4'd10;
    localparam logic [3:0] S_TRAP   = 4'd11;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b100;

    logic [3:0]       state_q;
    logic [3:0]       state_d;
    logic [5:0]       op_q;
    logic [5:0]       fn_q;
    logic             trap_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       r_alu;
    logic             r_ok;
    logic             retire;
    logic             strobe_en;

    // R-type function decode from the funct field latched in ID
    always_comb begin
        r_ok  = 1'b1;
        r_alu = ALU_ADD;
        case (fn_q)
            FN_ADD:  r_alu = ALU_ADD;
            FN_SUB:  r_alu = ALU_SUB;
            FN_AND:  r_alu = ALU_AND;
            FN_OR:   r_alu = ALU_OR;
            FN_SLT:  r_alu = ALU_SLT;
            default: r_ok  = 1'b0;
        endcase
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RST: state_d = S_IF;
            S_IF: if (mem_ready) state_d = S_ID;
            S_ID: begin
                case (opcode)
                    OP_R:         state_d = S_EX_R;
                    OP_LW, OP_SW: state_d = S_EX_AD;
                    OP_BEQ:       state_d = S_EX_BR;
                    OP_J:         state_d = S_EX_J;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_EX_R:   state_d = r_ok ? S_WB_R : S_TRAP;
            S_EX_AD:  state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
            S_MEM_WR: if (mem_ready) state_d = S_IF;
            S_WB_R, S_WB_MEM,
            S_EX_BR, S_EX_J: state_d = S_IF;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_RST;
        endcase
    end

    // An instruction retires on the edge leaving its final state
    always_comb begin
        retire = 1'b0;
        unique case (state_q)
            S_WB_R, S_WB_MEM,
            S_EX_BR, S_EX_J: retire = 1'b1;
            S_MEM_WR:        retire = mem_ready;
            default:         retire = 1'b0;
        endcase
    end

    // State, latched IR fields, sticky trap and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            op_q    <= '0;
            fn_q    <= '0;
            trap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_ID) begin
                op_q <= opcode;
                fn_q <= funct;
            end
            if (state_d == S_TRAP) trap_q <= 1'b1;
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Moore output decode; only IF and EX_BR look at live inputs
    always_comb begin
        pc_we     = 1'b0;
        pc_src    = 2'b00;
        ir_we     = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_iord  = 1'b0;
        reg_we    = 1'b0;
        reg_dst   = 1'b0;
        mem2reg   = 1'b0;
        alu_op    = ALU_ADD;
        strobe_en = 1'b1;
        unique case (state_q)
            S_IF: begin
                mem_rd = 1'b1;
                ir_we  = mem_ready;
                pc_we  = mem_ready;
            end
            S_ID:    ;
            S_EX_R:  alu_op = r_alu;
            S_EX_AD: ;
            S_MEM_RD: begin
                mem_rd   = 1'b1;
                mem_iord = 1'b1;
            end
            S_MEM_WR: begin
                mem_wr   = 1'b1;
                mem_iord = 1'b1;
            end
            S_WB_R: begin
                reg_we  = 1'b1;
                reg_dst = 1'b1;
            end
            S_WB_MEM: begin
                reg_we  = 1'b1;
                mem2reg = 1'b1;
            end
            S_EX_BR: begin
                alu_op = ALU_SUB;
                pc_we  = zero;
                pc_src = 2'b01;
            end
            S_EX_J: begin
                pc_we  = 1'b1;
                pc_src = 2'b10;
            end
            default: strobe_en = 1'b0;
        endcase
    end

    // Exactly one operand strobe outside RST/TRAP; ~B for sub and slt
    always_comb begin
        bn_sel = strobe_en &&
                 ((alu_op == ALU_SUB) || (alu_op == ALU_SLT));
        b_sel  = strobe_en && !bn_sel;
    end

    assign trap      = trap_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Testbench for mc_ctrl_fsm: table of instruction vectors plus stall,
// trap, counter-wrap and mid-instruction reset sequences, scoreboard checked.
module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        pc_we, ir_we, mem_rd, mem_wr, mem_iord;
    logic        reg_we, reg_dst, mem2reg, b_sel, bn_sel, trap;
    logic [1:0]  pc_src;
    logic [2:0]  alu_op;
    logic [15:0] instr_cnt;

    logic        d2_pc_we, d2_ir_we, d2_mem_rd, d2_mem_wr, d2_mem_iord;
    logic        d2_reg_we, d2_reg_dst, d2_mem2reg, d2_b_sel, d2_bn_sel;
    logic        d2_trap;
    logic [1:0]  d2_pc_src;
    logic [2:0]  d2_alu_op;
    logic [2:0]  d2_cnt;

    mc_ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .pc_we(pc_we),
        .pc_src(pc_src), .ir_we(ir_we), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_iord(mem_iord), .reg_we(reg_we),
        .reg_dst(reg_dst), .mem2reg(mem2reg), .b_sel(b_sel),
        .bn_sel(bn_sel), .alu_op(alu_op), .trap(trap),
        .instr_cnt(instr_cnt)
    );

    // Narrow-counter instance sharing stimulus: exercises counter wrap
    mc_ctrl_fsm #(.CNT_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .pc_we(d2_pc_we),
        .pc_src(d2_pc_src), .ir_we(d2_ir_we), .mem_rd(d2_mem_rd),
        .mem_wr(d2_mem_wr), .mem_iord(d2_mem_iord), .reg_we(d2_reg_we),
        .reg_dst(d2_reg_dst), .mem2reg(d2_mem2reg), .b_sel(d2_b_sel),
        .bn_sel(d2_bn_sel), .alu_op(d2_alu_op), .trap(d2_trap),
        .instr_cnt(d2_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic [5:0]        op;
        logic [5:0]        fn;
        logic              z;
        int                n;
        logic [0:4][15:0]  e;
    } vec_t;

    typedef struct {
        string       tag;
        logic [15:0] o;
        logic [15:0] cnt;
        logic [2:0]  cnt2;
    } exp_t;

    exp_t sbq[$];
    vec_t vt[10];
    int   nvec = 0;
    int   nmis = 0;
    int   exp_cnt = 0;

    logic [15:0] O_ZERO, IF_R, IF_W, ID, EXAD, MRD, MWR;
    logic [15:0] WBR, WBM, EXJ, TRAPO, BR1, BR0;

    function automatic logic [15:0] o(
        input logic pw, input logic [1:0] ps, input logic iw,
        input logic mr, input logic mw, input logic io,
        input logic rw, input logic rd, input logic m2r,
        input logic b, input logic bn, input logic [2:0] alu,
        input logic tr);
        return {pw, ps, iw, mr, mw, io, rw, rd, m2r, b, bn, alu, tr};
    endfunction

    function automatic logic [15:0] exr(input logic [2:0] alu,
                                        input logic bn);
        return o(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, !bn, bn, alu, 0);
    endfunction

    function automatic vec_t mk(input string nm, input logic [5:0] op,
        input logic [5:0] fn, input logic z, input int n,
        input logic [15:0] e0, input logic [15:0] e1,
        input logic [15:0] e2, input logic [15:0] e3,
        input logic [15:0] e4);
        vec_t v;
        v.name = nm;
        v.op   = op;
        v.fn   = fn;
        v.z    = z;
        v.n    = n;
        v.e    = {e0, e1, e2, e3, e4};
        return v;
    endfunction

    task automatic chk(input string tag, input logic [15:0] eo);
        exp_t e;
        logic [15:0] act;
        logic [15:0] ec;
        ec = exp_cnt[15:0];
        e.tag  = tag;
        e.o    = eo;
        e.cnt  = ec;
        e.cnt2 = ec[2:0];
        sbq.push_back(e);
        e = sbq.pop_front();
        act = {pc_we, pc_src, ir_we, mem_rd, mem_wr, mem_iord, reg_we,
               reg_dst, mem2reg, b_sel, bn_sel, alu_op, trap};
        nvec++;
        if (act !== e.o || instr_cnt !== e.cnt || d2_cnt !== e.cnt2) begin
            nmis++;
            $display("FAIL %s: outs=%h cnt=%h cnt3=%h, want outs=%h cnt=%h cnt3=%h",
                     e.tag, act, instr_cnt, d2_cnt, e.o, e.cnt, e.cnt2);
        end
    endtask

    task automatic cyc(input string tag, input logic [15:0] eo,
                       input logic mr);
        @(negedge clk);
        mem_ready = mr;
        #1;
        chk(tag, eo);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_cnt = 0;
        #1;
        chk("reset_async", O_ZERO);
        @(negedge clk);
        #1;
        chk("reset_hold", O_ZERO);
        rst_n = 1'b1;
        #1;
        chk("reset_release", O_ZERO);
    endtask

    task automatic run_vec(input vec_t v);
        opcode = v.op;
        funct  = v.fn;
        zero   = v.z;
        for (int c = 0; c < v.n; c++)
            cyc($sformatf("%s_c%0d", v.name, c), v.e[c], 1'b1);
        exp_cnt++;
    endtask

    initial begin
        O_ZERO = 16'h0;
        IF_R  = o(1, 2'b00, 1, 1, 0, 0, 0, 0, 0, 1, 0, 3'b000, 0);
        IF_W  = o(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 1, 0, 3'b000, 0);
        ID    = o(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000, 0);
        EXAD  = ID;
        MRD   = o(0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 1, 0, 3'b000, 0);
        MWR   = o(0, 2'b00, 0, 0, 1, 1, 0, 0, 0, 1, 0, 3'b000, 0);
        WBR   = o(0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 1, 0, 3'b000, 0);
        WBM   = o(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 1, 0, 3'b000, 0);
        EXJ   = o(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000, 0);
        BR1   = o(1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b100, 0);
        BR0   = o(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b100, 0);
        TRAPO = o(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1);

        vt[0] = mk("add", 6'h00, 6'b100000, 0, 4,
                   IF_R, ID, exr(3'b000, 0), WBR, 16'h0);
        vt[1] = mk("sub", 6'h00, 6'b100010, 0, 4,
                   IF_R, ID, exr(3'b100, 1), WBR, 16'h0);
        vt[2] = mk("and", 6'h00, 6'b100100, 0, 4,
                   IF_R, ID, exr(3'b001, 0), WBR, 16'h0);
        vt[3] = mk("or", 6'h00, 6'b100101, 1, 4,
                   IF_R, ID, exr(3'b010, 0), WBR, 16'h0);
        vt[4] = mk("slt", 6'h00, 6'b101010, 0, 4,
                   IF_R, ID, exr(3'b011, 1), WBR, 16'h0);
        vt[5] = mk("lw", 6'b100011, 6'h3f, 0, 5,
                   IF_R, ID, EXAD, MRD, WBM);
        vt[6] = mk("sw", 6'b101011, 6'h00, 0, 4,
                   IF_R, ID, EXAD, MWR, 16'h0);
        vt[7] = mk("beq_t", 6'b000100, 6'h00, 1, 3,
                   IF_R, ID, BR1, 16'h0, 16'h0);
        vt[8] = mk("beq_nt", 6'b000100, 6'h00, 0, 3,
                   IF_R, ID, BR0, 16'h0, 16'h0);
        vt[9] = mk("j", 6'b000010, 6'h00, 0, 3,
                   IF_R, ID, EXJ, 16'h0, 16'h0);

        rst_n = 1'b0;
        opcode = '0;
        funct = '0;
        zero = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", O_ZERO);
        rst_n = 1'b1;
        #1;
        chk("rst_to_if", O_ZERO);

        // ten instructions back to back; 3-bit counter wraps at eight
        for (int i = 0; i < 10; i++) run_vec(vt[i]);

        // lw with IF and MEM_RD stalls
        opcode = 6'b100011;
        funct  = 6'h00;
        cyc("lw_if_stall0", IF_W, 1'b0);
        cyc("lw_if_stall1", IF_W, 1'b0);
        cyc("lw_if", IF_R, 1'b1);
        cyc("lw_id", ID, 1'b1);
        cyc("lw_ex", EXAD, 1'b1);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("lw_mem_stall%0d", i), MRD, 1'b0);
        cyc("lw_mem_done", MRD, 1'b1);
        cyc("lw_wb", WBM, 1'b1);
        exp_cnt++;
        cyc("lw_next_if", IF_R, 1'b1);
        cyc("lw_next_id_noreg", ID, 1'b1);
        do_reset();

        // illegal R-type funct: EX_R with no writes, then absorbing TRAP
        opcode = 6'h00;
        funct  = 6'b111111;
        cyc("badfn_if", IF_R, 1'b1);
        cyc("badfn_id", ID, 1'b1);
        cyc("badfn_ex", exr(3'b000, 0), 1'b1);
        for (int i = 0; i < 100; i++) begin
            opcode = 6'($urandom_range(0, 63));
            zero   = 1'($urandom_range(0, 1));
            cyc($sformatf("trap_fn%0d", i), TRAPO,
                1'($urandom_range(0, 1)));
        end
        do_reset();

        // illegal opcode goes to TRAP straight from ID
        opcode = 6'b111111;
        cyc("badop_if", IF_R, 1'b1);
        cyc("badop_id", ID, 1'b1);
        for (int i = 0; i < 100; i++)
            cyc($sformatf("trap_op%0d", i), TRAPO, 1'b1);
        do_reset();

        // reset asserted while a store waits in MEM_WR
        opcode = 6'b101011;
        cyc("sw_if", IF_R, 1'b1);
        cyc("sw_id", ID, 1'b1);
        cyc("sw_ex", EXAD, 1'b1);
        cyc("sw_mem_wait", MWR, 1'b0);
        #2;
        mem_ready = 1'b1;
        #1;
        chk("sw_ready_same_cycle", MWR);
        rst_n = 1'b0;
        #1;
        chk("sw_reset_now", O_ZERO);
        @(negedge clk);
        #1;
        chk("sw_reset_noretire", O_ZERO);
        rst_n = 1'b1;
        #1;
        chk("sw_reset_release", O_ZERO);
        run_vec(vt[0]);
        cyc("after_add_if", IF_R, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
